vdp_port_ctrl: RTL
==================

Name: vdp_port_ctrl

Overview:
- CPU-side I/O controller for the TMS9918-style video block.
- Decodes the MSX data port (0x98) and control port (0x99). Sequences CPU accesses to VRAM port A, with auto-increment address and a read-ahead buffer.
- Holds VDP registers R0–R7 and drives the video block's configuration inputs (mode, table base addresses, colours, video_on).
- Owns the frame-interrupt status flag and n_int.

Parameters:
- ADDR_W, 14, VRAM address width.
- NREGS, 8, number of write-only VDP registers.

Ports:
- clk  in  1  CPU-domain clock (same clock as VRAM port A).
- reset  in  1  asynchronous, active-high reset.
- io_port  in  1  0 = data port, 1 = control port.
- io_wr  in  1  one-cycle write strobe.
- io_rd  in  1  one-cycle read strobe.
- io_din  in  8  CPU write data.
- io_dout  out  8  CPU read data, registered.
- vram_addr  out  14  VRAM port-A address.
- vram_wdata  out  8  VRAM write data.
- vram_wr  out  1  VRAM write strobe.
- vram_rd  out  1  VRAM read strobe; data is returned the next cycle.
- vram_rdata  in  8  VRAM read data.
- frame_int  in  1  one-cycle pulse at start of vblank.
- mode  out  2  display mode.
- name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr  out  14 each  table base addresses.
- video_on  out  1  display enable.
- text_color, back_color  out  4 each  text and background colours.
- n_int  out  1  interrupt, active-low.

Behaviour:
- Reset (async, active-high) clears all registers, the address, the read-ahead buffer, io_dout, the status flag F, and the first-byte flag. Resulting outputs: vram_wr=0, vram_rd=0, n_int=1, video_on=0, all base addresses=0, mode=1. Reset mid-sequence abandons any pending read; the next control write is again a first byte.
- Register decode:
  - R0[1]=M3. R1[6]=video_on, R1[5]=IE, R1[4]=M1, R1[3]=M2.
  - mode = M1?0 : M3?2 : M2?3 : 1.
  - name_table_addr = {R2[3:0],10'b0}.
  - color_table_addr = {R3,6'b0}.
  - font_addr = {R4[2:0],11'b0}.
  - sprite_attr_addr = {R5[6:0],7'b0}.
  - sprite_pattern_table_addr = {R6[2:0],11'b0}.
  - text_color = R7[7:4], back_color = R7[3:0].
- Control-port FSM, states FIRST and SECOND:
  - Write in FIRST: latch io_din into tmp, go to SECOND.
  - Write in SECOND, io_din[7]=1: R[io_din[2:0]] <= tmp; bits 6:3 ignored; go to FIRST.
  - Write in SECOND, io_din[7:6]=00: addr <= {io_din[5:0],tmp}; start a prefetch read; go to FIRST.
  - Write in SECOND, io_din[7:6]=01: addr <= {io_din[5:0],tmp}; no read; go to FIRST.
  - Any data-port access or control-port read forces FIRST.
- VRAM sequencer, states V_IDLE and V_RD:
  - Prefetch: cycle after the trigger, vram_addr=addr and vram_rd=1 for one cycle; addr increments. Next cycle (V_RD): buffer <= vram_rdata, return to V_IDLE.
  - Data write at cycle N: at N+1, vram_addr=addr, vram_wdata=io_din, vram_wr=1 for one cycle; buffer <= io_din; addr increments.
  - Data read at cycle N: io_dout <= buffer, valid at N+1; then a prefetch as above.
  - If a data write's vram_wr cycle coincides with a V_RD capture, the write's buffer update wins.
- Address arithmetic: 14-bit, wraps 0x3FFF -> 0x0000.
- CPU strobes are ≥3 cycles apart; io_wr and io_rd are never asserted together.
- Status:
  - F is set by frame_int.
  - Control-port read: io_dout <= {F,7'b0} at N+1, then F is cleared.
  - If frame_int arrives in the same cycle as the status read, F stays 1.
  - n_int = !(F & IE), registered; updates the cycle after F or IE changes.
- io_dout holds its value until the next read.

Test Plan:
- Reset, then check idle outputs -> mode=1, n_int=1, video_on=0, vram_wr=vram_rd=0, all base addresses 0.
- Control writes 0x06,0x82 then 0x60,0x81 -> R2=6 gives name_table_addr=0x1800; R1=0x60 gives video_on=1, IE=1, mode=1. Then 0x10,0x81 -> mode=0.
- Control writes 0x00,0x40, then data writes 0xAA,0xBB -> vram_wr at addr 0x0000 (0xAA) then 0x0001 (0xBB); vram_rd never asserted.
- Preload VRAM[0x3FFF]=0x11, [0x0000]=0x22; control writes 0xFF,0x3F; two data reads -> prefetch read at 0x3FFF; reads return 0x11 then 0x22; third prefetch address is 0x0001 (wrap).
- Single control write 0x34, then a status read, then control writes 0x05,0x87 -> the status read resets the FSM to FIRST, so the next two bytes form a register write: R7=0x05, text_color=0, back_color=5.
- IE=1, pulse frame_int -> n_int=0 one cycle later. Status read -> io_dout=0x80, n_int returns to 1. Status read coincident with frame_int -> F stays set, n_int stays 0.

Source files
------------

// File: rtl/vdp_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : vdp_port_ctrl_if
// Brief    : CPU I/O bus and VRAM port-A bus seen by the VDP port controller.
// Revision : 1.0
// ============================================================================
interface vdp_port_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              io_port;
    logic              io_wr;
    logic              io_rd;
    logic [7:0]        io_din;
    logic [7:0]        io_dout;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_wdata;
    logic              vram_wr;
    logic              vram_rd;
    logic [7:0]        vram_rdata;

    // System side: the CPU strobes plus the VRAM returning read data.
    modport master (
        output io_port, io_wr, io_rd, io_din, vram_rdata,
        input  io_dout, vram_addr, vram_wdata, vram_wr, vram_rd
    );

    modport slave (
        input  io_port, io_wr, io_rd, io_din, vram_rdata,
        output io_dout, vram_addr, vram_wdata, vram_wr, vram_rd
    );
endinterface
`default_nettype wire

// File: rtl/vdp_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vdp_port_ctrl
// Brief    : TMS9918-style CPU port controller: registers, VRAM access, status.
// Revision : 1.0
// ============================================================================
module vdp_port_ctrl #(
    parameter int ADDR_W = 14,
    parameter int NREGS  = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    vdp_port_ctrl_if.slave         bus,
    input  wire logic              frame_int,
    output logic [1:0]             mode,
    output logic [ADDR_W-1:0]      name_table_addr,
    output logic [ADDR_W-1:0]      color_table_addr,
    output logic [ADDR_W-1:0]      font_addr,
    output logic [ADDR_W-1:0]      sprite_attr_addr,
    output logic [ADDR_W-1:0]      sprite_pattern_table_addr,
    output logic                   video_on,
    output logic [3:0]             text_color,
    output logic [3:0]             back_color,
    output logic                   n_int
);

    typedef enum logic [0:0] {FIRST = 1'b0, SECOND = 1'b1} ctl_state_t;
    typedef enum logic [0:0] {V_IDLE = 1'b0, V_RD = 1'b1} vram_state_t;

    ctl_state_t        r_ctl_state;
    vram_state_t       r_vstate;
    logic [7:0]        r_regs [NREGS];
    logic [7:0]        r_tmp;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_buffer;
    logic [7:0]        r_io_dout;
    logic              r_flag;
    logic              r_n_int;
    logic [ADDR_W-1:0] r_vram_addr;
    logic [7:0]        r_vram_wdata;
    logic              r_vram_wr;
    logic              r_vram_rd;

    logic              w_data_wr;
    logic              w_data_rd;
    logic              w_ctl_wr;
    logic              w_ctl_rd;
    logic              w_set_addr;
    logic              w_start_rd;
    logic [ADDR_W-1:0] w_new_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_m1;
    logic              w_m2;
    logic              w_m3;
    logic              w_unused;

    assign w_data_wr  = bus.io_wr & ~bus.io_port;
    assign w_data_rd  = bus.io_rd & ~bus.io_port;
    assign w_ctl_wr   = bus.io_wr &  bus.io_port;
    assign w_ctl_rd   = bus.io_rd &  bus.io_port;

    // Second control byte with bit 7 clear loads the address; bit 6 clear also prefetches.
    assign w_set_addr = w_ctl_wr & (r_ctl_state == SECOND) & ~bus.io_din[7];
    assign w_start_rd = w_data_rd | (w_set_addr & ~bus.io_din[6]);
    assign w_new_addr = {bus.io_din[5:0], r_tmp};
    assign w_rd_addr  = w_data_rd ? r_addr : w_new_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ctl_state  <= FIRST;
            r_vstate     <= V_IDLE;
            r_tmp        <= '0;
            r_addr       <= '0;
            r_buffer     <= '0;
            r_io_dout    <= '0;
            r_flag       <= 1'b0;
            r_n_int      <= 1'b1;
            r_vram_addr  <= '0;
            r_vram_wdata <= '0;
            r_vram_wr    <= 1'b0;
            r_vram_rd    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_vram_wr <= 1'b0;
            r_vram_rd <= 1'b0;

            if (w_data_wr || w_data_rd || w_ctl_rd) begin
                r_ctl_state <= FIRST;
            end else if (w_ctl_wr) begin
                case (r_ctl_state)
                    FIRST: begin
                        r_tmp       <= bus.io_din;
                        r_ctl_state <= SECOND;
                    end
                    default: begin
                        r_ctl_state <= FIRST;
                        if (bus.io_din[7]) begin
                            r_regs[bus.io_din[2:0]] <= r_tmp;
                        end else begin
                            r_addr <= w_new_addr;
                        end
                    end
                endcase
            end

            if (w_data_wr) begin
                r_vram_wr    <= 1'b1;
                r_vram_addr  <= r_addr;
                r_vram_wdata <= bus.io_din;
                r_addr       <= r_addr + ADDR_W'(1);
            end

            if (w_start_rd) begin
                r_vram_rd   <= 1'b1;
                r_vram_addr <= w_rd_addr;
                r_addr      <= w_rd_addr + ADDR_W'(1);
            end

            // V_RD is the cycle the VRAM returns data for the previous vram_rd.
            case (r_vstate)
                V_IDLE:  if (r_vram_rd) r_vstate <= V_RD;
                default: r_vstate <= V_IDLE;
            endcase

            if (r_vram_wr) begin
                r_buffer <= r_vram_wdata;
            end else if (r_vstate == V_RD) begin
                r_buffer <= bus.vram_rdata;
            end

            if (w_data_rd) begin
                r_io_dout <= r_buffer;
            end else if (w_ctl_rd) begin
                r_io_dout <= {r_flag, 7'b0};
            end

            // A frame pulse coincident with the status read keeps the flag set.
            if (frame_int) begin
                r_flag <= 1'b1;
            end else if (w_ctl_rd) begin
                r_flag <= 1'b0;
            end

            r_n_int <= ~(r_flag & r_regs[1][5]);
        end
    end

    assign w_m1 = r_regs[1][4];
    assign w_m2 = r_regs[1][3];
    assign w_m3 = r_regs[0][1];

    assign mode = w_m1 ? 2'd0 : (w_m3 ? 2'd2 : (w_m2 ? 2'd3 : 2'd1));

    assign name_table_addr           = {r_regs[2][3:0], 10'b0};
    assign color_table_addr          = {r_regs[3], 6'b0};
    assign font_addr                 = {r_regs[4][2:0], 11'b0};
    assign sprite_attr_addr          = {r_regs[5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {r_regs[6][2:0], 11'b0};
    assign video_on                  = r_regs[1][6];
    assign text_color                = r_regs[7][7:4];
    assign back_color                = r_regs[7][3:0];
    assign n_int                     = r_n_int;

    assign bus.io_dout    = r_io_dout;
    assign bus.vram_addr  = r_vram_addr;
    assign bus.vram_wdata = r_vram_wdata;
    assign bus.vram_wr    = r_vram_wr;
    assign bus.vram_rd    = r_vram_rd;

    assign w_unused = ^{r_regs[0][7:2], r_regs[0][0], r_regs[1][7], r_regs[1][2:0],
                        r_regs[2][7:4], r_regs[4][7:3], r_regs[5][7], r_regs[6][7:3]};

endmodule
`default_nettype wire
